// File: rtl/pantheon_wb_arb_pkg.sv
// Shared types and constants for the 2:1 Wishbone memory arbiter.
package pantheon_wb_arb_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 2;

    localparam logic [WB_DW-1:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    // Master-to-slave half of a Wishbone port, muxed as one bundle.
    typedef struct packed {
        logic             stb;
        logic             cyc;
        logic             we;
        logic [WB_AW-1:0] addr;
        logic [WB_SW-1:0] width;
        logic [WB_DW-1:0] data_write;
    } wb_req_t;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone bundle used between core masters, the arbiter and the memory slave.
interface WISHBONE_IF;

    logic                                  stb;
    logic                                  cyc;
    logic                                  we;
    logic [pantheon_wb_arb_pkg::WB_AW-1:0] addr;
    logic [pantheon_wb_arb_pkg::WB_SW-1:0] width;
    logic [pantheon_wb_arb_pkg::WB_DW-1:0] data_write;
    logic [pantheon_wb_arb_pkg::WB_DW-1:0] data_read;
    logic                                  ack;

    modport master (output stb, cyc, we, addr, width, data_write, input data_read, ack);
    modport slave  (input stb, cyc, we, addr, width, data_write, output data_read, ack);

endinterface

// File: rtl/wb_mem_arbiter_timeout.sv
// Stalled-access watchdog: counts owner wait cycles and emits a one-cycle expire.
module wb_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expire_q, expire_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (clr || expire_q) begin
            cnt_d = '0;
        end else if (inc) begin
            expire_d = (cnt_q == CNT_LAST);
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/wb_mem_arbiter.sv
// 2:1 round-robin Wishbone arbiter with locked grants in front of the on-chip memory.
// Optional stalled-access abort enabled by defining WB_MEM_ARBITER_TIMEOUT_EN.
module wb_mem_arbiter
    import pantheon_wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          RESET_PRIO     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    WISHBONE_IF.slave        m0_wb,
    WISHBONE_IF.slave        m1_wb,
    WISHBONE_IF.master       s_wb,
    output logic [1:0]       owner,
    output logic             timeout
);

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    logic             req0, req1;
    logic             gnt0, gnt1;
    logic             fwd_ack;
    logic             expire;
    logic [WB_DW-1:0] own_rdata;
    wb_req_t          own;

    assign req0 = m0_wb.cyc & m0_wb.stb;
    assign req1 = m1_wb.cyc & m1_wb.stb;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (req0 && req1)  state_d = last_q ? ARB_GNT0 : ARB_GNT1;
                else if (req0)     state_d = ARB_GNT0;
                else if (req1)     state_d = ARB_GNT1;
            end
            ARB_GNT0: begin
                if (!m0_wb.cyc) begin
                    last_d  = 1'b0;
                    state_d = req1 ? ARB_GNT1 : ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                if (!m1_wb.cyc) begin
                    last_d  = 1'b1;
                    state_d = req0 ? ARB_GNT0 : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            last_q  <= ~RESET_PRIO;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign owner = {state_q == ARB_GNT1, state_q == ARB_GNT0};

    // Routing is cut while rst is high so an in-flight access is never acked.
    assign gnt0 = (state_q == ARB_GNT0) && !rst;
    assign gnt1 = (state_q == ARB_GNT1) && !rst;

    always_comb begin
        own = '0;
        if (gnt0) begin
            own = '{stb: m0_wb.stb, cyc: m0_wb.cyc, we: m0_wb.we, addr: m0_wb.addr,
                    width: m0_wb.width, data_write: m0_wb.data_write};
        end else if (gnt1) begin
            own = '{stb: m1_wb.stb, cyc: m1_wb.cyc, we: m1_wb.we, addr: m1_wb.addr,
                    width: m1_wb.width, data_write: m1_wb.data_write};
        end
    end

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
    logic grant_entry;
    assign grant_entry = (state_d != state_q) && (state_d != ARB_IDLE);

    wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (grant_entry | fwd_ack),
        .inc    (own.stb & own.cyc & ~s_wb.ack),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    assign timeout = expire;

    // Slave ack only counts while the owner strobes and no abort is in progress.
    assign fwd_ack   = own.stb & ~expire & s_wb.ack;
    assign own_rdata = expire ? ARB_ERR_DATA : s_wb.data_read;

    assign s_wb.stb        = own.stb & ~expire;
    assign s_wb.cyc        = own.cyc;
    assign s_wb.we         = own.we;
    assign s_wb.addr       = own.addr;
    assign s_wb.width      = own.width;
    assign s_wb.data_write = own.data_write;

    assign m0_wb.ack       = gnt0 & (fwd_ack | expire);
    assign m1_wb.ack       = gnt1 & (fwd_ack | expire);
    assign m0_wb.data_read = gnt0 ? own_rdata : '0;
    assign m1_wb.data_read = gnt1 ? own_rdata : '0;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboard bench for wb_mem_arbiter with a combinational-ack ROM slave model.
module tb_wb_mem_arbiter;
    import pantheon_wb_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] owner;
    logic       timeout;
    logic       ack_en = 1'b1;
    logic       seen_bad;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];

    logic [31:0] hold_exp [5] = '{32'hF6F7F4F5, 32'hF2F3F0F1, 32'hFEFFFCFD,
                                  32'hFAFBF8F9, 32'hC6C7C4C5};

    WISHBONE_IF m0_if ();
    WISHBONE_IF m1_if ();
    WISHBONE_IF s_if ();

    wb_mem_arbiter #(
        .TIMEOUT_CYCLES(4),
        .RESET_PRIO    (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_wb   (m0_if),
        .m1_wb   (m1_if),
        .s_wb    (s_if),
        .owner   (owner),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Memory slave: byte at address a holds a ^ 8'hA5, word is little-endian.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = (a[7:0] + 8'(i)) ^ 8'hA5;
        return w;
    endfunction

    always_comb begin
        s_if.ack       = ack_en & s_if.stb & s_if.cyc;
        s_if.data_read = rom_word(s_if.addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack a master sees must match the oldest expectation for it.
    always @(negedge clk) begin
        if (m0_if.ack === 1'b1) begin
            if (exp0.size() == 0) begin
                checks++; failures++;
                $display("FAIL m0_unexpected_ack: got ack data %h expected no ack", m0_if.data_read);
            end else check("m0_data", m0_if.data_read, exp0.pop_front());
        end
        if (m1_if.ack === 1'b1) begin
            if (exp1.size() == 0) begin
                checks++; failures++;
                $display("FAIL m1_unexpected_ack: got ack data %h expected no ack", m1_if.data_read);
            end else check("m1_data", m1_if.data_read, exp1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input bit req, input logic [31:0] addr,
                         input bit we, input logic [31:0] wdata);
        if (m == 0) begin
            m0_if.stb = req; m0_if.cyc = req; m0_if.we = we;
            m0_if.addr = addr; m0_if.width = 2'd2; m0_if.data_write = wdata;
        end else begin
            m1_if.stb = req; m1_if.cyc = req; m1_if.we = we;
            m1_if.addr = addr; m1_if.width = 2'd2; m1_if.data_write = wdata;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_s_stb", 32'(s_if.stb), 32'h0);
        check("rst_s_cyc", 32'(s_if.cyc), 32'h0);
        check("rst_m0_ack", 32'(m0_if.ack), 32'h0);
        check("rst_m0_data", m0_if.data_read, 32'h0);
        check("rst_m1_data", m1_if.data_read, 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        tick();
        rst = 1'b0;

        // Lone m0 read: one cycle of arbitration latency, then zero-latency ack.
        drive(0, 1'b1, 32'h10, 1'b0, '0);
        exp0.push_back(32'hB6B7B4B5);
        @(negedge clk);
        check("t1_latency_owner", 32'(owner), 32'h0);
        check("t1_latency_s_stb", 32'(s_if.stb), 32'h0);
        tick();
        @(negedge clk);
        check("t1_owner", 32'(owner), 32'h1);
        check("t1_s_addr", s_if.addr, 32'h10);
        check("t1_s_width", 32'(s_if.width), 32'h2);
        check("t1_m1_ack", 32'(m1_if.ack), 32'h0);
        tick();
        drive(0, 1'b0, '0, 1'b0, '0);
        tick();
        @(negedge clk);
        check("t1_back_idle", 32'(owner), 32'h0);

        // Simultaneous requests after reset, direct handoff, round-robin back.
        do_reset();
        drive(0, 1'b1, 32'h20, 1'b0, '0);
        drive(1, 1'b1, 32'h30, 1'b0, '0);
        exp0.push_back(32'h86878485);
        exp1.push_back(32'h96979495);
        @(negedge clk);
        check("t2_idle_latency", 32'(owner), 32'h0);
        tick();
        @(negedge clk);
        check("t2_reset_prio", 32'(owner), 32'h1);
        check("t2_m1_ack_blocked", 32'(m1_if.ack), 32'h0);
        tick();
        drive(0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check("t2_exit_on_edge", 32'(owner), 32'h1);
        tick();
        @(negedge clk);
        check("t2_handoff_no_bubble", 32'(owner), 32'h2);
        tick();
        drive(1, 1'b0, '0, 1'b0, '0);
        drive(0, 1'b1, 32'h40, 1'b0, '0);
        exp0.push_back(32'hE6E7E4E5);
        @(negedge clk);
        check("t2_m1_release", 32'(owner), 32'h2);
        tick();
        @(negedge clk);
        check("t2_rr_back_m0", 32'(owner), 32'h1);
        tick();
        drive(0, 1'b0, '0, 1'b0, '0);
        tick();
        @(negedge clk);
        check("t2_idle", 32'(owner), 32'h0);

        // From IDLE with m0 last: contention goes to m1, which locks for 5 accesses.
        drive(0, 1'b1, 32'h70, 1'b0, '0);
        drive(1, 1'b1, 32'h50, 1'b0, '0);
        exp0.push_back(32'hD6D7D4D5);
        exp1.push_back(hold_exp[0]);
        tick();
        @(negedge clk);
        check("t3_rr_from_idle", 32'(owner), 32'h2);
        check("t3_m0_ack_0", 32'(m0_if.ack), 32'h0);
        for (int k = 1; k < 5; k++) begin
            tick();
            drive(1, 1'b1, 32'h50 + 32'(4 * k), k == 2, 32'hCAFE0000 + 32'(k));
            exp1.push_back(hold_exp[k]);
            @(negedge clk);
            check("t3_locked_owner", 32'(owner), 32'h2);
            check("t3_m0_ack_held", 32'(m0_if.ack), 32'h0);
            if (k == 2) begin
                check("t3_s_we", 32'(s_if.we), 32'h1);
                check("t3_s_wdata", s_if.data_write, 32'hCAFE0002);
            end
        end
        tick();
        drive(1, 1'b0, '0, 1'b0, '0);
        tick();
        @(negedge clk);
        check("t3_m0_after_release", 32'(owner), 32'h1);
        tick();
        drive(0, 1'b0, '0, 1'b0, '0);
        tick();

        // Reset while m1 is stalled in GNT1.
        ack_en = 1'b0;
        drive(1, 1'b1, 32'h80, 1'b0, '0);
        tick();
        @(negedge clk);
        check("t4_stall_owner", 32'(owner), 32'h2);
        check("t4_stall_s_stb", 32'(s_if.stb), 32'h1);
        tick();
        rst = 1'b1;
        tick();
        ack_en = 1'b1;
        @(negedge clk);
        check("t4_rst_owner", 32'(owner), 32'h0);
        check("t4_rst_m0_ack", 32'(m0_if.ack), 32'h0);
        check("t4_rst_m1_ack", 32'(m1_if.ack), 32'h0);
        check("t4_rst_s_stb", 32'(s_if.stb), 32'h0);
        tick();
        rst = 1'b0;
        drive(1, 1'b0, '0, 1'b0, '0);
        tick();

        // Slave never acks a lone m0 read.
        ack_en = 1'b0;
        drive(0, 1'b1, 32'h10, 1'b0, '0);
`ifdef WB_MEM_ARBITER_TIMEOUT_EN
        exp0.push_back(ARB_ERR_DATA);
        @(negedge clk);
        check("t5_pre_grant", 32'(owner), 32'h0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("t5_wait_ack", 32'(m0_if.ack), 32'h0);
            check("t5_wait_timeout", 32'(timeout), 32'h0);
            tick();
        end
        @(negedge clk);
        check("t5_timeout_pulse", 32'(timeout), 32'h1);
        check("t5_abort_ack", 32'(m0_if.ack), 32'h1);
        check("t5_abort_s_stb", 32'(s_if.stb), 32'h0);
        tick();
        drive(0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check("t5_pulse_single", 32'(timeout), 32'h0);
        check("t5_grant_kept", 32'(owner), 32'h1);
        tick();
        @(negedge clk);
        check("t5_idle", 32'(owner), 32'h0);
`else
        seen_bad = 1'b0;
        tick();
        repeat (200) begin
            @(negedge clk);
            if (m0_if.ack !== 1'b0 || timeout !== 1'b0) seen_bad = 1'b1;
        end
        check("t5_no_ack_no_timeout", 32'(seen_bad), 32'h0);
        check("t5_owner_held", 32'(owner), 32'h1);
        tick();
        drive(0, 1'b0, '0, 1'b0, '0);
        tick();
`endif
        ack_en = 1'b1;
        tick();

        check("exp0_drained", 32'(exp0.size()), 32'h0);
        check("exp1_drained", 32'(exp1.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
